// File: rtl/mips_cpu_pc_fetch_if.sv
// Avalon-style instruction read port between the fetch stage (master) and
// instruction memory (slave).
interface mips_cpu_pc_fetch_if;
    logic [31:0] address;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address,
        output read,
        input  waitrequest,
        input  readdata
    );

    modport slave (
        input  address,
        input  read,
        output waitrequest,
        output readdata
    );
endinterface

// File: rtl/mips_cpu_pc_fetch.sv
// PC / instruction-fetch stage of the multicycle MIPS CPU: FETCH -> EXEC loop
// with branch-delay-slot PC sequencing and halt on a committed jump to 0.
module mips_cpu_pc_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic                       clk,
    input  logic                       reset,
    mips_cpu_pc_fetch_if.master        imem,
    input  logic [1:0]                 CtrlPC,
    input  logic [31:0]                RsData,
    input  logic                       exec_stall,
    output logic [31:0]                Instr,
    output logic                       instr_valid,
    output logic [31:0]                pc,
    output logic [31:0]                pc_plus8,
    output logic                       active
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pending_target;
    logic        r_delay_pending;
    logic        r_instr_valid;
    logic        r_active;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_off;
    logic [31:0] w_target;

    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_branch_off = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

    always_comb begin
        w_target = '0;
        case (CtrlPC)
            2'd1:    w_target = w_pc_plus4 + w_branch_off;
            2'd2:    w_target = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
            2'd3:    w_target = RsData & ~32'h3;
            default: w_target = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= ST_FETCH;
            r_pc             <= RESET_VECTOR;
            r_instr          <= '0;
            r_delay_pending  <= 1'b0;
            r_pending_target <= '0;
            r_instr_valid    <= 1'b0;
            r_active         <= 1'b1;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (!imem.waitrequest) begin
                        r_instr       <= imem.readdata;
                        r_state       <= ST_EXEC;
                        r_instr_valid <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (!exec_stall) begin
                        r_instr_valid <= 1'b0;
                        // A delay slot's own CtrlPC is dropped; the stored target wins.
                        if (r_delay_pending) begin
                            r_pc            <= r_pending_target;
                            r_delay_pending <= 1'b0;
                            if (r_pending_target == '0) begin
                                r_state  <= ST_HALTED;
                                r_active <= 1'b0;
                            end else begin
                                r_state <= ST_FETCH;
                            end
                        end else begin
                            r_pc    <= w_pc_plus4;
                            r_state <= ST_FETCH;
                            if (CtrlPC != 2'd0) begin
                                r_pending_target <= w_target;
                                r_delay_pending  <= 1'b1;
                            end
                        end
                    end
                end
                ST_HALTED: begin
                    r_state <= ST_HALTED;
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    assign imem.address = r_pc;
    assign imem.read    = (r_state == ST_FETCH) && !reset;
    assign Instr        = r_instr;
    assign instr_valid  = r_instr_valid;
    assign pc           = r_pc;
    assign pc_plus8     = r_pc + 32'd8;
    assign active       = r_active;

endmodule

// File: tb/tb_mips_cpu_pc_fetch.sv
// Scoreboard bench for mips_cpu_pc_fetch: expected fetch addresses and commit
// PCs are queued per scenario and checked by a negedge monitor.
module tb_mips_cpu_pc_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        waitreq;
    logic        exec_stall;
    logic [31:0] RsData;
    logic [1:0]  CtrlPC;
    logic [31:0] Instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus8;
    logic        active;

    logic [31:0] prog [0:63];
    logic [31:0] q_fetch [$];
    logic [31:0] q_exec [$];
    logic [31:0] mon_exp;
    int          n_cmp = 0;
    int          n_fail = 0;

    mips_cpu_pc_fetch_if bus ();

    mips_cpu_pc_fetch #(.RESET_VECTOR(32'hBFC00000)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem       (bus.master),
        .CtrlPC     (CtrlPC),
        .RsData     (RsData),
        .exec_stall (exec_stall),
        .Instr      (Instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .pc_plus8   (pc_plus8),
        .active     (active)
    );

    always #5 clk = ~clk;

    // Boot ROM window at 0xBFC000xx; everything else reads as NOP.
    assign bus.readdata    = (bus.address[31:8] == 24'hBFC000) ? prog[bus.address[7:2]] : 32'h0;
    assign bus.waitrequest = waitreq;

    // Minimal decoder: BEQ always taken, J, JR.
    assign CtrlPC = !instr_valid ? 2'd0 :
                    (Instr[31:26] == 6'h04) ? 2'd1 :
                    (Instr[31:26] == 6'h02) ? 2'd2 :
                    (Instr[31:26] == 6'h00 && Instr[5:0] == 6'h08) ? 2'd3 : 2'd0;

    always @(negedge clk) begin
        if (bus.read && !bus.waitrequest && q_fetch.size() != 0) begin
            mon_exp = q_fetch.pop_front();
            n_cmp++;
            if (bus.address !== mon_exp) begin
                n_fail++;
                $display("FAIL fetch_addr: got %h want %h", bus.address, mon_exp);
            end
        end
        if (instr_valid && !exec_stall && q_exec.size() != 0) begin
            mon_exp = q_exec.pop_front();
            n_cmp++;
            if (pc !== mon_exp || pc_plus8 !== mon_exp + 32'd8) begin
                n_fail++;
                $display("FAIL commit_pc: got pc=%h pc_plus8=%h want %h/%h",
                         pc, pc_plus8, mon_exp, mon_exp + 32'd8);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        q_fetch.delete();
        q_exec.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if (bus.read !== 1'b0 || instr_valid !== 1'b0 || active !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_flags: got read=%b iv=%b active=%b want 0 0 1", bus.read, instr_valid, active);
        end
        n_cmp++;
        if (bus.address !== 32'hBFC00000 || pc !== 32'hBFC00000 || pc_plus8 !== 32'hBFC00008) begin
            n_fail++;
            $display("FAIL reset_pc: got addr=%h pc=%h p8=%h want bfc00000/bfc00000/bfc00008", bus.address, pc, pc_plus8);
        end
        n_cmp++;
        if (Instr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_instr: got %h want 00000000", Instr);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.read !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_read: got %b want 1", bus.read);
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 64; i++) prog[i] = 32'h0;
        do_reset();
        q_fetch.push_back(32'hBFC00000); q_fetch.push_back(32'hBFC00004); q_fetch.push_back(32'hBFC00008);
        q_exec.push_back(32'hBFC00000);  q_exec.push_back(32'hBFC00004);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if (instr_valid !== logic'(i % 2)) begin
                n_fail++;
                $display("FAIL seq_instr_valid: cycle %0d got %b want %0d", i, instr_valid, i % 2);
            end
        end
        for (int c = 0; c < 60 && (q_fetch.size() + q_exec.size()) != 0; c++) begin @(negedge clk); #1; end
        n_cmp++;
        if ((q_fetch.size() + q_exec.size()) != 0) begin
            n_fail++;
            $display("FAIL seq_drain: got %0d pending want 0", q_fetch.size() + q_exec.size());
        end
    endtask

    task automatic test_wait_states();
        prog[0] = 32'h21080001;
        waitreq = 1'b1;
        do_reset();
        q_fetch.push_back(32'hBFC00000); q_fetch.push_back(32'hBFC00004);
        q_exec.push_back(32'hBFC00000);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.read !== 1'b1 || bus.address !== 32'hBFC00000 || Instr !== 32'h0) begin
                n_fail++;
                $display("FAIL wait_hold: cycle %0d got read=%b addr=%h instr=%h want 1/bfc00000/00000000",
                         k, bus.read, bus.address, Instr);
            end
            @(posedge clk);
            #1;
            if (k == 2) waitreq = 1'b0;
        end
        @(negedge clk);
        n_cmp++;
        if (Instr !== 32'h21080001 || instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_load: got instr=%h iv=%b want 21080001/1", Instr, instr_valid);
        end
        for (int c = 0; c < 60 && (q_fetch.size() + q_exec.size()) != 0; c++) begin @(negedge clk); #1; end
        n_cmp++;
        if ((q_fetch.size() + q_exec.size()) != 0) begin
            n_fail++;
            $display("FAIL wait_drain: got %0d pending want 0", q_fetch.size() + q_exec.size());
        end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 64; i++) prog[i] = 32'h0;
        prog[0] = 32'h10000003;   // BEQ imm=3
        prog[1] = 32'h08000100;   // J in the delay slot, must be ignored
        do_reset();
        q_fetch.push_back(32'hBFC00000); q_fetch.push_back(32'hBFC00004);
        q_fetch.push_back(32'hBFC00010); q_fetch.push_back(32'hBFC00014);
        q_exec.push_back(32'hBFC00000);  q_exec.push_back(32'hBFC00004); q_exec.push_back(32'hBFC00010);
        for (int c = 0; c < 60 && (q_fetch.size() + q_exec.size()) != 0; c++) begin @(negedge clk); #1; end
        n_cmp++;
        if ((q_fetch.size() + q_exec.size()) != 0) begin
            n_fail++;
            $display("FAIL branch_drain: got %0d pending want 0", q_fetch.size() + q_exec.size());
        end
    endtask

    task automatic test_jump();
        for (int i = 0; i < 64; i++) prog[i] = 32'h0;
        prog[0] = 32'h08000100;   // J index 0x100
        do_reset();
        q_fetch.push_back(32'hBFC00000); q_fetch.push_back(32'hBFC00004); q_fetch.push_back(32'hB0000400);
        q_exec.push_back(32'hBFC00000);  q_exec.push_back(32'hBFC00004);  q_exec.push_back(32'hB0000400);
        for (int c = 0; c < 60 && (q_fetch.size() + q_exec.size()) != 0; c++) begin @(negedge clk); #1; end
        n_cmp++;
        if ((q_fetch.size() + q_exec.size()) != 0) begin
            n_fail++;
            $display("FAIL jump_drain: got %0d pending want 0", q_fetch.size() + q_exec.size());
        end
        prog[0] = 32'h00200008;   // JR $1
        RsData  = 32'h00001237;
        do_reset();
        q_fetch.push_back(32'hBFC00000); q_fetch.push_back(32'hBFC00004); q_fetch.push_back(32'h00001234);
        q_exec.push_back(32'hBFC00000);  q_exec.push_back(32'hBFC00004);  q_exec.push_back(32'h00001234);
        for (int c = 0; c < 60 && (q_fetch.size() + q_exec.size()) != 0; c++) begin @(negedge clk); #1; end
        n_cmp++;
        if ((q_fetch.size() + q_exec.size()) != 0 || pc !== 32'h00001234) begin
            n_fail++;
            $display("FAIL jr_drain: got %0d pending pc=%h want 0 pending pc=00001234",
                     q_fetch.size() + q_exec.size(), pc);
        end
    endtask

    task automatic test_halt();
        for (int i = 0; i < 64; i++) prog[i] = 32'h0;
        prog[0] = 32'h00200008;   // JR $1 with $1 = 0
        RsData  = 32'h0;
        do_reset();
        q_fetch.push_back(32'hBFC00000); q_fetch.push_back(32'hBFC00004);
        q_exec.push_back(32'hBFC00000);  q_exec.push_back(32'hBFC00004);
        for (int c = 0; c < 60 && (q_fetch.size() + q_exec.size()) != 0; c++) begin @(negedge clk); #1; end
        n_cmp++;
        if ((q_fetch.size() + q_exec.size()) != 0 || active !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_slot: got %0d pending active=%b want 0 pending active=1",
                     q_fetch.size() + q_exec.size(), active);
        end
        @(negedge clk);
        n_cmp++;
        if (active !== 1'b0 || bus.read !== 1'b0 || instr_valid !== 1'b0 || bus.address !== 32'h0) begin
            n_fail++;
            $display("FAIL halt_enter: got active=%b read=%b iv=%b addr=%h want 0 0 0 00000000",
                     active, bus.read, instr_valid, bus.address);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.read !== 1'b0 || active !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_stay: cycle %0d got read=%b active=%b want 0 0", i, bus.read, active);
            end
        end
        do_reset();
        @(negedge clk);
        n_cmp++;
        if (active !== 1'b1 || bus.address !== 32'hBFC00000 || bus.read !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_reset: got active=%b addr=%h read=%b want 1/bfc00000/1", active, bus.address, bus.read);
        end
    endtask

    task automatic test_stall_and_reset();
        for (int i = 0; i < 64; i++) prog[i] = 32'h0;
        prog[0] = 32'h21080001;
        exec_stall = 1'b1;
        do_reset();
        q_fetch.push_back(32'hBFC00000); q_fetch.push_back(32'hBFC00004);
        q_exec.push_back(32'hBFC00000);
        for (int c = 0; c < 20 && !instr_valid; c++) begin @(negedge clk); #1; end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (pc !== 32'hBFC00000 || Instr !== 32'h21080001 || instr_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold: cycle %0d got pc=%h instr=%h iv=%b want bfc00000/21080001/1",
                         i, pc, Instr, instr_valid);
            end
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        exec_stall = 1'b0;
        for (int c = 0; c < 60 && (q_fetch.size() + q_exec.size()) != 0; c++) begin @(negedge clk); #1; end
        n_cmp++;
        if ((q_fetch.size() + q_exec.size()) != 0) begin
            n_fail++;
            $display("FAIL stall_drain: got %0d pending want 0", q_fetch.size() + q_exec.size());
        end

        prog[0] = 32'h08000100;   // J; reset lands while its delay slot is being fetched
        do_reset();
        for (int c = 0; c < 20 && !(bus.read && bus.address == 32'hBFC00004); c++) begin @(negedge clk); #1; end
        #1;
        reset = 1'b1;
        q_fetch.delete();
        q_exec.delete();
        prog[0] = 32'h0;
        #1;
        n_cmp++;
        if (bus.address !== 32'hBFC00000 || bus.read !== 1'b0 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got addr=%h read=%b iv=%b want bfc00000/0/0", bus.address, bus.read, instr_valid);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        q_fetch.push_back(32'hBFC00000); q_fetch.push_back(32'hBFC00004); q_fetch.push_back(32'hBFC00008);
        q_exec.push_back(32'hBFC00000);  q_exec.push_back(32'hBFC00004);
        for (int c = 0; c < 60 && (q_fetch.size() + q_exec.size()) != 0; c++) begin @(negedge clk); #1; end
        n_cmp++;
        if ((q_fetch.size() + q_exec.size()) != 0) begin
            n_fail++;
            $display("FAIL reset_discard_drain: got %0d pending want 0", q_fetch.size() + q_exec.size());
        end
    endtask

    initial begin
        waitreq    = 1'b0;
        exec_stall = 1'b0;
        RsData     = 32'h0;
        for (int i = 0; i < 64; i++) prog[i] = 32'h0;
        #1;
        reset = 1'b1;
        test_reset();
        test_sequential();
        test_wait_states();
        test_branch();
        test_jump();
        test_halt();
        test_stall_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
